// File: rtl/fp_pkg.sv
// Shared definitions for the sequential FP add/subtract unit: FSM states, flag layout
// and canonical special-value encodings parameterised on exponent/fraction widths.
package fp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } fp_state_e;

  localparam int unsigned FLAG_W    = 4;
  localparam int unsigned FLAG_NAN  = 3;
  localparam int unsigned FLAG_OVF  = 2;
  localparam int unsigned FLAG_UNF  = 1;
  localparam int unsigned FLAG_ZERO = 0;

  // Special-value helpers build a wide word; callers narrow it with W'().
  localparam int unsigned FP_MAX_W = 64;

  typedef logic [FP_MAX_W-1:0] fp_word_t;
  typedef logic [FLAG_W-1:0]   fp_flags_t;

  function automatic fp_flags_t fp_mk_flags(input logic nan_f, input logic ovf_f,
                                            input logic unf_f, input logic zero_f);
    fp_flags_t f;
    f            = '0;
    f[FLAG_NAN]  = nan_f;
    f[FLAG_OVF]  = ovf_f;
    f[FLAG_UNF]  = unf_f;
    f[FLAG_ZERO] = zero_f;
    return f;
  endfunction

  function automatic fp_word_t fp_exp_ones(input int unsigned exp_w, input int unsigned man_w);
    return ((fp_word_t'(1) << exp_w) - fp_word_t'(1)) << man_w;
  endfunction

  function automatic fp_word_t fp_zero(input logic sign, input int unsigned exp_w,
                                       input int unsigned man_w);
    return fp_word_t'(sign) << (exp_w + man_w);
  endfunction

  function automatic fp_word_t fp_inf(input logic sign, input int unsigned exp_w,
                                      input int unsigned man_w);
    return fp_zero(sign, exp_w, man_w) | fp_exp_ones(exp_w, man_w);
  endfunction

  // Quiet NaN: positive sign, all-ones exponent, fraction MSB set.
  function automatic fp_word_t fp_qnan(input int unsigned exp_w, input int unsigned man_w);
    return fp_exp_ones(exp_w, man_w) | (fp_word_t'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Combinational right shifter for significand alignment; bits shifted out are
// OR-ed into the sticky (LSB) position.
module fp_align_shift #(
  parameter int unsigned SIG_W = 27,
  parameter int unsigned SH_W  = 8
) (
  input  logic [SIG_W-1:0] sig_i,
  input  logic [SH_W-1:0]  shamt_i,
  output logic [SIG_W-1:0] sig_o
);

  // Shifting this far or more leaves only the sticky bit.
  localparam int unsigned SAT = SIG_W - 1;

  logic [SIG_W-1:0] mask;
  logic [SIG_W-1:0] shifted;
  logic             sticky;

  always_comb begin
    mask    = ~({SIG_W{1'b1}} << shamt_i);
    shifted = sig_i >> shamt_i;
    sticky  = |(sig_i & mask);
    sig_o   = {shifted[SIG_W-1:1], shifted[0] | sticky};
    if (32'(shamt_i) >= 32'(SAT)) begin
      sig_o = {{(SIG_W-1){1'b0}}, |sig_i};
    end
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract with valid/ready handshakes and a GRS datapath.
// Define FP_ADD_RNE_EN for round-to-nearest-even; otherwise ROUND truncates.
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter  int unsigned EXP_W = 8,
  parameter  int unsigned MAN_W = 23,
  localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int unsigned SIG_W = MAN_W + 4;
  localparam int unsigned SUM_W = MAN_W + 5;

  fp_state_e        state_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [EXP_W-1:0] exp_q;
  logic             sign_q;
  logic             eff_sub_q;
  logic             unf_q;
  logic [SIG_W-1:0] sig_l_q;
  logic [SIG_W-1:0] sig_s_q;
  logic [SUM_W-1:0] sum_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [W-1:0]     result_q;
  fp_flags_t        flags_q;

  logic             sgn_a, sgn_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;

  assign {sgn_a, exp_a, frac_a} = a_q;
  assign {sgn_b, exp_b, frac_b} = b_q;

  // Operand with the larger {exp,frac} magnitude becomes L; exp 0 flushes to zero.
  logic             a_big_d;
  logic             sgn_l_d, sgn_s_d;
  logic [EXP_W-1:0] exp_l_d, exp_s_d;
  logic [MAN_W-1:0] frac_l_d, frac_s_d;
  logic [SIG_W-1:0] sig_l_d, sig_s_d, sig_s_al_d;
  logic [EXP_W-1:0] shamt_d;

  assign a_big_d  = {exp_a, frac_a} >= {exp_b, frac_b};
  assign sgn_l_d  = a_big_d ? sgn_a  : sgn_b;
  assign sgn_s_d  = a_big_d ? sgn_b  : sgn_a;
  assign exp_l_d  = a_big_d ? exp_a  : exp_b;
  assign exp_s_d  = a_big_d ? exp_b  : exp_a;
  assign frac_l_d = a_big_d ? frac_a : frac_b;
  assign frac_s_d = a_big_d ? frac_b : frac_a;
  assign sig_l_d  = (exp_l_d == '0) ? '0 : {1'b1, frac_l_d, 3'b000};
  assign sig_s_d  = (exp_s_d == '0) ? '0 : {1'b1, frac_s_d, 3'b000};
  assign shamt_d  = exp_l_d - exp_s_d;

  fp_align_shift #(
    .SIG_W (SIG_W),
    .SH_W  (EXP_W)
  ) u_align_shift (
    .sig_i   (sig_s_d),
    .shamt_i (shamt_d),
    .sig_o   (sig_s_al_d)
  );

  // Any all-ones exponent (NaN or infinity) yields the canonical quiet NaN.
  logic             is_nan_d;
  logic [SUM_W-1:0] sum_d;

  assign is_nan_d = (&exp_a) | (&exp_b);
  assign sum_d    = eff_sub_q ? ({1'b0, sig_l_q} - {1'b0, sig_s_q})
                              : ({1'b0, sig_l_q} + {1'b0, sig_s_q});

`ifdef FP_ADD_RNE_EN
  // Round up when G is set and any of R, S or the fraction LSB is set.
  logic             rnd_up_d;
  logic [MAN_W:0]   rnd_frac_d;

  assign rnd_up_d   = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
  assign rnd_frac_d = {1'b0, sum_q[MAN_W+2:3]} + (MAN_W+1)'(rnd_up_d);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      eff_sub_q   <= 1'b0;
      unf_q       <= 1'b0;
      sig_l_q     <= '0;
      sig_s_q     <= '0;
      sum_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= {b[W-1] ^ sub, b[W-2:0]};
            in_ready_q <= 1'b0;
            state_q    <= ST_ALIGN;
          end
        end

        ST_ALIGN: begin
          sig_l_q   <= sig_l_d;
          sig_s_q   <= sig_s_al_d;
          exp_q     <= exp_l_d;
          sign_q    <= sgn_l_d;
          eff_sub_q <= sgn_l_d ^ sgn_s_d;
          unf_q     <= 1'b0;
          state_q   <= ST_ADD;
        end

        ST_ADD: begin
          if (is_nan_d) begin
            result_q    <= W'(fp_qnan(EXP_W, MAN_W));
            flags_q     <= fp_mk_flags(1'b1, 1'b0, 1'b0, 1'b0);
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (sum_d == '0) begin
            result_q    <= W'(fp_zero(1'b0, EXP_W, MAN_W));
            flags_q     <= fp_mk_flags(1'b0, 1'b0, 1'b0, 1'b1);
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            sum_q   <= sum_d;
            state_q <= ST_NORM;
          end
        end

        // Carry-out is fixed in one step; otherwise shift left one bit per cycle.
        ST_NORM: begin
          if (sum_q[SUM_W-1]) begin
            sum_q   <= {1'b0, sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
            exp_q   <= exp_q + EXP_W'(1);
            state_q <= ST_ROUND;
          end else if (sum_q[SUM_W-2]) begin
            state_q <= ST_ROUND;
          end else if (exp_q <= EXP_W'(1)) begin
            unf_q   <= 1'b1;
            state_q <= ST_ROUND;
          end else begin
            sum_q <= sum_q << 1;
            exp_q <= exp_q - EXP_W'(1);
          end
        end

        ST_ROUND: begin
          if (unf_q) begin
            result_q    <= W'(fp_zero(sign_q, EXP_W, MAN_W));
            flags_q     <= fp_mk_flags(1'b0, 1'b0, 1'b1, 1'b1);
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (&exp_q) begin
            result_q    <= W'(fp_inf(sign_q, EXP_W, MAN_W));
            flags_q     <= fp_mk_flags(1'b0, 1'b1, 1'b0, 1'b0);
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
`ifdef FP_ADD_RNE_EN
          end else if (rnd_frac_d[MAN_W]) begin
            // Rounding carried past the hidden bit: renormalise and re-check overflow.
            sum_q <= {2'b01, {(SUM_W-2){1'b0}}};
            exp_q <= exp_q + EXP_W'(1);
          end else begin
            result_q    <= {sign_q, exp_q, rnd_frac_d[MAN_W-1:0]};
            flags_q     <= fp_mk_flags(1'b0, 1'b0, 1'b0, 1'b0);
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
`else
          end else begin
            result_q    <= {sign_q, exp_q, sum_q[MAN_W+2:3]};
            flags_q     <= fp_mk_flags(1'b0, 1'b0, 1'b0, 1'b0);
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
`endif
        end

        // Result and flags hold until the consumer takes them.
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq (binary32): expected results are queued at accept
// and compared when the unit hands its result over.
module tb_fp_addsub_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  fp_addsub_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

`ifdef FP_ADD_RNE_EN
  localparam logic [31:0] R_RND_A   = 32'h3F800001;
  localparam logic [31:0] R_RND_TIE = 32'h3F800002;
  localparam logic [31:0] R_RND_CY  = 32'h40000000;
  localparam int          L_RND_CY  = 5;
`else
  localparam logic [31:0] R_RND_A   = 32'h3F800000;
  localparam logic [31:0] R_RND_TIE = 32'h3F800001;
  localparam logic [31:0] R_RND_CY  = 32'h3FFFFFFF;
  localparam int          L_RND_CY  = 4;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Present operands until accepted; optionally queue the expected result.
  task automatic send(input string tag, input logic [31:0] av, input logic [31:0] bv,
                      input logic sv, input logic [31:0] er, input logic [3:0] ef,
                      input int lat, input bit track);
    int n = 0;
    a        = av;
    b        = bv;
    sub      = sv;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk({tag, "_accept_timeout"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (track) sb_q.push_back('{tag: tag, res: er, flg: ef, lat: lat, acc: cyc});
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || !in_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  // Output side: latency on the rising edge of out_valid, payload at handshake.
  logic ov_prev = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev && sb_q.size() != 0 && sb_q[0].lat > 0)
        chk({sb_q[0].tag, "_latency"}, 64'(cyc - sb_q[0].acc), 64'(sb_q[0].lat));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          chk({e.tag, "_result"}, 64'(result), 64'(e.res));
          chk({e.tag, "_flags"}, 64'(flags), 64'(e.flg));
        end
      end
      ov_prev = out_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    sub       = 1'b0;

    vecs.push_back('{"add",       32'h41280000, 32'h40500000, 1'b0, 32'h415C0000, 4'b0000, 4});
    vecs.push_back('{"sub_flip",  32'h40500000, 32'h41280000, 1'b1, 32'hC0E80000, 4'b0000, 5});
    vecs.push_back('{"cancel",    32'h41280000, 32'h41280000, 1'b1, 32'h00000000, 4'b0001, 2});
    vecs.push_back('{"overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0100, 4});
    vecs.push_back('{"round",     32'h3F800000, 32'h33C00000, 1'b0, R_RND_A,      4'b0000, 4});
    vecs.push_back('{"round_tie", 32'h3F800001, 32'h33800000, 1'b0, R_RND_TIE,    4'b0000, 4});
    vecs.push_back('{"tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000, 4});
    vecs.push_back('{"round_cy",  32'h3FFFFFFF, 32'h33C00000, 1'b0, R_RND_CY,     4'b0000, L_RND_CY});
    vecs.push_back('{"nan_in",    32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 2});
    vecs.push_back('{"inf_in",    32'h7F800000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 2});
    vecs.push_back('{"denorm",    32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b0001, 2});
    vecs.push_back('{"underflow", 32'h80800001, 32'h80800000, 1'b1, 32'h80000000, 4'b0011, 4});
    vecs.push_back('{"carry",     32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000, 4});
    vecs.push_back('{"zero_op",   32'h00000000, 32'h40500000, 1'b0, 32'h40500000, 4'b0000, 4});
    vecs.push_back('{"long_norm", 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000, 27});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      send(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].res, vecs[i].flg,
           vecs[i].lat, 1'b1);
      drain();
    end

    // Back-pressure: result held, no new accept while DONE, then handoff via IDLE.
    out_ready = 1'b0;
    send("hold", 32'h41280000, 32'h40500000, 1'b0, 32'h415C0000, 4'b0000, 4, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_wait_valid", 64'(out_valid), 64'd1);
    a        = 32'h3FC00000;
    b        = 32'h3FC00000;
    sub      = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'(result), 64'h415C0000);
      chk("hold_flags", 64'(flags), 64'd0);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b_in_ready_after_done", 64'(in_ready), 64'd1);
    chk("b2b_out_valid_after_done", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("b2b_accepted", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    sb_q.push_back('{tag: "b2b", res: 32'h40400000, flg: 4'b0000, lat: 4, acc: cyc});
    drain();

    // Reset while normalising discards the operation.
    send("abort", 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_flags", 64'(flags), 64'd0);
    rst_n = 1'b1;
    send("post_rst", 32'h41280000, 32'h40500000, 1'b0, 32'h415C0000, 4'b0000, 4, 1'b1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("end_out_valid", 64'(out_valid), 64'd0);
    chk("end_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
- Parametrised, multi-cycle IEEE-754-style floating-point add/subtract unit. Successor to the single-precision combinational adder.
- Adds operation select (add/sub), valid/ready handshakes on both sides, guard/round/sticky datapath, and exception flags.
- Exponent and mantissa widths are generic. Default is binary32.
- Sits between the operand memory fetch and the result/compare stage of the FP test harness.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width (hidden bit excluded).
- Derived constant: W = 1 + EXP_W + MAN_W (word width).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  unit idle, accepts operands.
- a  in  W  operand A.
- b  in  W  operand B.
- sub  in  1  1 = A-B, 0 = A+B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  sum/difference.
- flags  out  4  {nan, ovf, unf, zero}.

Behaviour:
- Reset: on rst_n low at a clk edge, the FSM goes to IDLE. Outputs reset to in_ready=1, out_valid=0, result=0, flags=0. Reset applied mid-operation aborts and discards the result.
- Accept: the transaction occurs on a cycle with in_valid & in_ready. a, b and sub are registered; beff = b with sign XOR sub.
- FSM states: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
  - IDLE -> ALIGN on accept.
  - ALIGN -> ADD.
  - ADD -> NORM, or directly to DONE for special cases or an exact zero.
  - NORM -> ROUND.
  - ROUND -> DONE.
  - DONE -> IDLE on out_valid & out_ready.
  - in_ready=1 only in IDLE.
- ALIGN:
  - Swap so the operand with the larger {exp,frac} magnitude is L.
  - Significands are {hidden, frac, G, R, S} (MAN_W+4 bits); hidden bit = (exp != 0).
  - Right-shift S by d = expL - expS. Bits shifted out OR into S.
  - If d >= MAN_W+3, the shifted value is 0 and S = OR of the significand.
- ADD:
  - Same effective sign: add into MAN_W+5 bits.
  - Otherwise: L - S, result sign = sign of L.
  - Exact zero result -> +0, zero=1.
- NORM:
  - Carry out: one right shift (sticky preserved), exp+1, in a single cycle.
  - Otherwise: left-shift one bit per cycle until the hidden bit is set, decrementing exp each cycle.
  - Worst case MAN_W+2 cycles.
  - If exp reaches 0 before normalising: flush to signed zero, unf=1, zero=1.
- ROUND: truncation by default (GRS dropped).
- Overflow: if the final exp reaches all-ones, result = signed infinity (frac 0), ovf=1.
- Specials, resolved in ADD:
  - Any input exp all-ones -> canonical quiet NaN {0, all-ones, 1 followed by zeros}, nan=1. Infinities are also treated as NaN in this generation.
  - Input exp 0 -> treated as zero (denormals flushed).
- Latency: accept-to-out_valid = 4 + (number of left normalise shifts) cycles.
- DONE: result and flags are held stable while out_valid=1 and out_ready=0. Results are never dropped or overwritten.
- Simultaneous out_ready and in_valid in DONE: the unit returns to IDLE first. The new operands are accepted the following cycle, because in_ready was 0 in DONE.

Optional Feature:
- Macro: FP_ADD_RNE_EN.
- Defined: ROUND performs round-to-nearest-even using G, R, S and the LSB.
  - A rounding carry into the hidden+1 position right-shifts once and increments exp, with overflow re-checked.
  - ROUND may take 2 cycles in that case.
- Undefined: truncation; ROUND is always 1 cycle.

Decomposition:
- Package fp_pkg holds:
  - FSM state enum.
  - Flag bit indices.
  - Functions/constants for the canonical NaN, infinity and zero, parameterised on EXP_W/MAN_W.
- One natural sub-module: fp_align_shift, a combinational right shifter with sticky OR, instantiated in ALIGN.

Test Plan:
- Add, binary32: a=0x41280000, b=0x40500000, sub=0 -> result 0x415C0000, flags 0, out_valid 4 cycles after accept.
- Subtract with sign flip: a=0x40500000, b=0x41280000, sub=1 -> result 0xC0E80000 (-7.25).
- Cancellation: a=b=0x41280000, sub=1 -> result 0x00000000, zero=1, skips NORM. Overflow case: a=b=0x7F7FFFFF, sub=0 -> result 0x7F800000, ovf=1.
- Rounding: a=0x3F800000, b=0x33C00000 -> 0x3F800001 with FP_ADD_RNE_EN, 0x3F800000 without.
- Handshake:
  - Hold out_ready=0 for 5 cycles -> result stable and in_ready=0 throughout.
  - A back-to-back in_valid is accepted only after the DONE->IDLE handoff.
  - NaN input 0x7FC00000 -> 0x7FC00000, nan=1.
- Reset mid-NORM (a=0x3F800001, b=0x3F800000, sub=1) -> next cycle in_ready=1, out_valid=0, result=0. A subsequent op completes correctly.
